// File: rtl/sipo_frame_rx.sv
// Serial-to-parallel frame receiver with a one-entry valid/ready output buffer.
// Frame: start bit 1, WIDTH data bits LSB first, optional even parity bit, stop bit 0.
// Optional feature macro: SIPO_PARITY_EN (adds the parity bit and drives parity_err).
module sipo_frame_rx #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             serial_in,
  input  logic             bit_en,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             frame_err,
  output logic             overrun,
  output logic             parity_err
);

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              valid_q, valid_d;
  logic              ferr_q, ferr_d;
  logic              ovr_q, ovr_d;
  logic              stop_good;
  logic              commit;
  logic              par_mismatch;

`ifdef SIPO_PARITY_EN
  logic par_bad_q, par_bad_d;
  logic perr_q, perr_d;
  assign par_mismatch = par_bad_q;
  assign parity_err   = perr_q;
`else
  assign par_mismatch = 1'b0;
  assign parity_err   = 1'b0;
`endif

  // State register plus all datapath and output flops; reset wins over everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
`ifdef SIPO_PARITY_EN
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
`ifdef SIPO_PARITY_EN
      par_bad_q <= par_bad_d;
      perr_q    <= perr_d;
`endif
    end
  end

  // Next-state logic; the FSM only advances on bit strobes.
  always_comb begin
    state_d = state_q;
    if (bit_en) begin
      unique case (state_q)
        StIdle: if (serial_in) state_d = StData;
        StData: begin
          if (cnt_q == CntW'(WIDTH - 1)) begin
`ifdef SIPO_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
        StParity: state_d = StStop;
        StStop:   state_d = StIdle;
        default:  state_d = StIdle;
      endcase
    end
  end

  // Datapath, error pulses and output-buffer handshake.
  always_comb begin
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    stop_good = 1'b0;
    ferr_d    = 1'b0;
`ifdef SIPO_PARITY_EN
    par_bad_d = par_bad_q;
`endif
    if (bit_en) begin
      unique case (state_q)
        StIdle: begin
          if (serial_in) begin
            cnt_d = '0;
`ifdef SIPO_PARITY_EN
            par_bad_d = 1'b0;
`endif
          end
        end
        StData: begin
          shift_d[cnt_q] = serial_in;
          cnt_d          = cnt_q + CntW'(1);
        end
`ifdef SIPO_PARITY_EN
        StParity: par_bad_d = serial_in ^ (^shift_q);
`endif
        StStop: begin
          // A 1 here is a framing error and is not taken as the next start bit.
          if (serial_in) ferr_d = 1'b1;
          else           stop_good = 1'b1;
        end
        default: ;
      endcase
    end

    commit = stop_good & ~par_mismatch;
`ifdef SIPO_PARITY_EN
    perr_d = stop_good & par_mismatch;
`endif

    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    if (valid_q && data_ready) valid_d = 1'b0;
    if (commit) begin
      // Buffer full and not draining this edge: drop the new word.
      if (valid_q && !data_ready) begin
        ovr_d = 1'b1;
      end else begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Directed self-checking bench for sipo_frame_rx (WIDTH=8).
module tb_sipo_frame_rx;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       serial_in = 1'b0;
  logic       bit_en = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready = 1'b1;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  int n_checks = 0;
  int n_fail   = 0;

  sipo_frame_rx #(.WIDTH(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .serial_in  (serial_in),
    .bit_en     (bit_en),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One bit strobe, preceded by gap cycles with bit_en low.
  task automatic strobe(input logic b, input int gap);
    bit_en    = 1'b0;
    serial_in = b;
    repeat (gap) tick();
    bit_en = 1'b1;
    tick();
    bit_en = 1'b0;
  endtask

  // Whole frame; returns 1 time unit after the stop-bit edge.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int gap,
                            input logic rdy_at_stop, input logic pflip);
    strobe(1'b1, gap);
    for (int i = 0; i < 8; i++) strobe(d[i], gap);
`ifdef SIPO_PARITY_EN
    strobe((^d) ^ pflip, gap);
`endif
    if (rdy_at_stop) data_ready = 1'b1;
    strobe(stop, gap);
  endtask

  task automatic check_outputs(input string tag, input logic [7:0] d, input logic v,
                               input logic fe, input logic ov, input logic pe);
    check({tag, ".data_out"}, {8'h00, data_out}, {8'h00, d});
    check({tag, ".data_valid"}, {15'h0, data_valid}, {15'h0, v});
    check({tag, ".frame_err"}, {15'h0, frame_err}, {15'h0, fe});
    check({tag, ".overrun"}, {15'h0, overrun}, {15'h0, ov});
    check({tag, ".parity_err"}, {15'h0, parity_err}, {15'h0, pe});
  endtask

  initial begin
    // Reset with hostile inputs asserted.
    bit_en    = 1'b1;
    serial_in = 1'b1;
    reset     = 1'b1;
    tick();
    tick();
    check_outputs("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    reset     = 1'b0;
    bit_en    = 1'b0;
    serial_in = 1'b0;
    tick();

    // Basic receive with the consumer always ready.
    data_ready = 1'b1;
    send_frame(8'h5C, 1'b0, 0, 1'b0, 1'b0);
    check_outputs("basic", 8'h5C, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check("basic.drain", {15'h0, data_valid}, 16'h0000);

    // Backpressure: second word is dropped with an overrun pulse.
    data_ready = 1'b0;
    send_frame(8'h5C, 1'b0, 0, 1'b0, 1'b0);
    check_outputs("bp.first", 8'h5C, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'hCC, 1'b0, 0, 1'b0, 1'b0);
    check_outputs("bp.second", 8'h5C, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    check("bp.ovr_pulse", {15'h0, overrun}, 16'h0000);
    check("bp.hold", {8'h00, data_out}, 16'h005C);
    data_ready = 1'b1;
    tick();
    check("bp.accept", {15'h0, data_valid}, 16'h0000);

    // Commit and accept on the same edge.
    data_ready = 1'b0;
    send_frame(8'h5C, 1'b0, 0, 1'b0, 1'b0);
    check("sim.pre", {15'h0, data_valid}, 16'h0001);
    send_frame(8'h00, 1'b0, 0, 1'b1, 1'b0);
    check_outputs("sim", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check("sim.drain", {15'h0, data_valid}, 16'h0000);

    // Framing error, then a good frame right after.
    data_ready = 1'b1;
    send_frame(8'hCC, 1'b1, 0, 1'b0, 1'b0);
    check("ferr.pulse", {15'h0, frame_err}, 16'h0001);
    check("ferr.valid", {15'h0, data_valid}, 16'h0000);
    tick();
    check("ferr.clear", {15'h0, frame_err}, 16'h0000);
    send_frame(8'h5C, 1'b0, 0, 1'b0, 1'b0);
    check_outputs("ferr.next", 8'h5C, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();

    // Strobe every third cycle.
    send_frame(8'hCC, 1'b0, 2, 1'b0, 1'b0);
    check_outputs("gated", 8'hCC, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check("gated.drain", {15'h0, data_valid}, 16'h0000);

    // Reset mid-frame with a word buffered.
    data_ready = 1'b0;
    send_frame(8'hCC, 1'b0, 0, 1'b0, 1'b0);
    check("rst.buffered", {15'h0, data_valid}, 16'h0001);
    strobe(1'b1, 0);
    for (int i = 0; i < 4; i++) strobe(i[0], 0);
    reset = 1'b1;
    tick();
    check_outputs("rst.mid", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    reset      = 1'b0;
    data_ready = 1'b1;
    send_frame(8'h5C, 1'b0, 0, 1'b0, 1'b0);
    check_outputs("rst.after", 8'h5C, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();

`ifdef SIPO_PARITY_EN
    // 8'h5C has four ones, so even parity bit is 0.
    send_frame(8'h5C, 1'b0, 0, 1'b0, 1'b0);
    check_outputs("par.good", 8'h5C, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    send_frame(8'h5C, 1'b0, 0, 1'b0, 1'b1);
    check_outputs("par.bad", 8'h5C, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check("par.clear", {15'h0, parity_err}, 16'h0000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
